// File: rtl/rgb_to_yuv_encoder.sv
// RGB-to-BT.601 YUV encoder: reads interleaved RGB groups from SRAM and writes Y/U/V planes.
// Optional macro UV_AVG_EN selects averaged chroma; otherwise even-pixel chroma decimation.
module rgb_to_yuv_encoder #(
   parameter logic [17:0] Y_BASE     = 18'd0,
   parameter logic [17:0] U_BASE     = 18'd38400,
   parameter logic [17:0] V_BASE     = 18'd57600,
   parameter logic [17:0] RGB_BASE   = 18'd146944,
   parameter int          NUM_GROUPS = 19200
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        Enable,
   output logic        Done,
   output logic [17:0] SRAM_address,
   input  logic [15:0] SRAM_read_data,
   output logic [15:0] SRAM_write_data,
   output logic        SRAM_we_n
);

   localparam int G_W   = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
   localparam int OFF_W = $clog2(6 * NUM_GROUPS + 1);
`ifdef UV_AVG_EN
   localparam int UV_N = 4;
`else
   localparam int UV_N = 2;
`endif

   typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_CALC, S_WR, S_DONE} state_t;

   state_t             state, state_nxt;
   logic [3:0]         cnt;
   logic [G_W-1:0]     g;
   logic [OFF_W-1:0]   rgb_off;
   logic               last_grp;

   logic [7:0]         pix [12];
   logic [7:0]         y_q [4];
   logic signed [15:0] u_q [UV_N];
   logic signed [15:0] v_q [UV_N];

   logic               cap_en;
   logic [2:0]         cap_w;
   logic [1:0]         calc_p, calc_c;
   logic [3:0]         pix_idx;
   logic signed [31:0] r_p0, g_p0, b_p0, ka_p0, kb_p0, kc_p0, off_p0, sum_p0, res_p0;
   logic [7:0]         ue0, ue1, ve0, ve1;

   function automatic logic [7:0] clamp8(input logic signed [31:0] v);
      if (v < 0)
         return 8'd0;
      else if (v > 32'sd255)
         return 8'd255;
      else
         return v[7:0];
   endfunction

`ifdef UV_AVG_EN
   function automatic logic signed [31:0] avg2(input logic signed [31:0] a, input logic signed [31:0] b);
      return (a + b + 32'sd1) >>> 1;
   endfunction
`endif

   assign last_grp = (g == G_W'(NUM_GROUPS - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (Enable) state_nxt = S_RD;
         S_RD:   if (cnt == 4'd5) state_nxt = S_WAIT;
         S_WAIT: if (cnt == 4'd1) state_nxt = S_CALC;
         S_CALC: if (cnt == 4'd11) state_nxt = S_WR;
         S_WR:   if (cnt == 4'd3) state_nxt = last_grp ? S_DONE : S_RD;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Capture: word k arrives two cycles after its address, i.e. during RD k+2 / WAIT k-4
   assign cap_en = ((state == S_RD) && (cnt >= 4'd2)) || (state == S_WAIT);
   assign cap_w  = (state == S_RD) ? 3'(cnt - 4'd2) : 3'(cnt + 4'd4);

   always_comb begin
      calc_p  = 2'(cnt / 4'd3);
      calc_c  = 2'(cnt % 4'd3);
      pix_idx = 4'({2'b00, calc_p} * 4'd3);
      r_p0    = $signed({24'd0, pix[pix_idx]});
      g_p0    = $signed({24'd0, pix[4'(pix_idx + 4'd1)]});
      b_p0    = $signed({24'd0, pix[4'(pix_idx + 4'd2)]});
      ka_p0   = 32'sd28770;
      kb_p0   = -32'sd24117;
      kc_p0   = -32'sd4653;
      off_p0  = 32'sd128;
      case (calc_c)
         2'd0: begin ka_p0 = 32'sd16843; kb_p0 = 32'sd33030;  kc_p0 = 32'sd6423;  off_p0 = 32'sd16;  end
         2'd1: begin ka_p0 = -32'sd9699; kb_p0 = -32'sd19071; kc_p0 = 32'sd28770; off_p0 = 32'sd128; end
         default: ;
      endcase
      sum_p0 = r_p0 * ka_p0 + g_p0 * kb_p0 + b_p0 * kc_p0 + 32'sd32768;
      res_p0 = (sum_p0 >>> 16) + off_p0;
   end

   always_comb begin
`ifdef UV_AVG_EN
      ue0 = clamp8(avg2(32'(u_q[0]), 32'(u_q[1])));
      ue1 = clamp8(avg2(32'(u_q[2]), 32'(u_q[3])));
      ve0 = clamp8(avg2(32'(v_q[0]), 32'(v_q[1])));
      ve1 = clamp8(avg2(32'(v_q[2]), 32'(v_q[3])));
`else
      ue0 = clamp8(32'(u_q[0]));
      ue1 = clamp8(32'(u_q[1]));
      ve0 = clamp8(32'(v_q[0]));
      ve1 = clamp8(32'(v_q[1]));
`endif
   end

   always_ff @(posedge Clock) begin
      if (cap_en) begin
         pix[{cap_w, 1'b0}] <= SRAM_read_data[15:8];
         pix[{cap_w, 1'b1}] <= SRAM_read_data[7:0];
      end
      if (state == S_CALC) begin
         case (calc_c)
            2'd0: y_q[calc_p] <= clamp8(res_p0);
`ifdef UV_AVG_EN
            2'd1: u_q[calc_p] <= res_p0[15:0];
            default: v_q[calc_p] <= res_p0[15:0];
`else
            2'd1: if (!calc_p[0]) u_q[calc_p[1]] <= res_p0[15:0];
            default: if (!calc_p[0]) v_q[calc_p[1]] <= res_p0[15:0];
`endif
         endcase
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state           <= S_IDLE;
         cnt             <= '0;
         g               <= '0;
         rgb_off         <= '0;
         SRAM_address    <= '0;
         SRAM_write_data <= '0;
         SRAM_we_n       <= 1'b1;
         Done            <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= (state_nxt != state) ? 4'd0 : 4'(cnt + 4'd1);
         Done  <= 1'b0;
         case (state)
            S_IDLE: begin
               SRAM_we_n <= 1'b1;
               if (Enable) begin
                  g            <= '0;
                  rgb_off      <= '0;
                  SRAM_address <= RGB_BASE;
               end
            end
            S_RD: if (cnt != 4'd5) SRAM_address <= SRAM_address + 18'd1;
            S_CALC: if (cnt == 4'd11) begin
               SRAM_address    <= Y_BASE + 18'({g, 1'b0});
               SRAM_write_data <= {y_q[0], y_q[1]};
               SRAM_we_n       <= 1'b0;
            end
            S_WR: begin
               case (cnt)
                  4'd0: begin
                     SRAM_address    <= Y_BASE + 18'({g, 1'b0}) + 18'd1;
                     SRAM_write_data <= {y_q[2], y_q[3]};
                  end
                  4'd1: begin
                     SRAM_address    <= U_BASE + 18'(g);
                     SRAM_write_data <= {ue0, ue1};
                  end
                  4'd2: begin
                     SRAM_address    <= V_BASE + 18'(g);
                     SRAM_write_data <= {ve0, ve1};
                  end
                  default: begin
                     SRAM_we_n <= 1'b1;
                     if (last_grp) begin
                        Done <= 1'b1;
                     end else begin
                        g            <= g + G_W'(1);
                        rgb_off      <= rgb_off + OFF_W'(6);
                        SRAM_address <= RGB_BASE + 18'(rgb_off) + 18'd6;
                     end
                  end
               endcase
            end
            S_DONE: SRAM_we_n <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rgb_to_yuv_encoder.sv
// Directed testbench for rgb_to_yuv_encoder on a reduced 8-group frame with a 2-cycle-latency SRAM model.
module tb_rgb_to_yuv_encoder;

   localparam int          NG = 8;
   localparam logic [17:0] YB = 18'd0;
   localparam logic [17:0] UB = 18'd38400;
   localparam logic [17:0] VB = 18'd57600;
   localparam logic [17:0] RB = 18'd146944;

   logic        Clock = 1'b0;
   logic        Resetn;
   logic        Enable;
   logic        Done;
   logic [17:0] SRAM_address;
   logic [15:0] SRAM_read_data;
   logic [15:0] SRAM_write_data;
   logic        SRAM_we_n;

   logic [15:0] src [0:262143];
   logic [15:0] dst [0:262143];
   logic [15:0] rd_p1, rd_p2;
   int unsigned wr_cnt = 0;

   int checks = 0;
   int errors = 0;

   rgb_to_yuv_encoder #(.NUM_GROUPS(NG)) dut (
      .Clock(Clock),
      .Resetn(Resetn),
      .Enable(Enable),
      .Done(Done),
      .SRAM_address(SRAM_address),
      .SRAM_read_data(SRAM_read_data),
      .SRAM_write_data(SRAM_write_data),
      .SRAM_we_n(SRAM_we_n)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) begin
      rd_p1 <= src[SRAM_address];
      rd_p2 <= rd_p1;
      if (!SRAM_we_n) begin
         dst[SRAM_address] <= SRAM_write_data;
         wr_cnt <= wr_cnt + 1;
      end
   end
   assign SRAM_read_data = rd_p2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_grp(input int g, input logic [15:0] w [6]);
      for (int k = 0; k < 6; k++) src[int'(RB) + 6 * g + k] = w[k];
   endtask

   task automatic chk_grp(input int g, input logic [15:0] ey0, input logic [15:0] ey1,
                          input logic [15:0] eu, input logic [15:0] ev);
      chk($sformatf("g%0d_y0", g), 32'(dst[int'(YB) + 2 * g]), 32'(ey0));
      chk($sformatf("g%0d_y1", g), 32'(dst[int'(YB) + 2 * g + 1]), 32'(ey1));
      chk($sformatf("g%0d_u", g), 32'(dst[int'(UB) + g]), 32'(eu));
      chk($sformatf("g%0d_v", g), 32'(dst[int'(VB) + g]), 32'(ev));
   endtask

   // Returns frame length counted from the Enable cycle to the Done cycle inclusive (-1 if no Done).
   task automatic run_frame(input int pulse_at, output int frame_cyc, output int dones);
      frame_cyc = -1;
      dones     = 0;
      @(negedge Clock);
      Enable = 1'b1;
      for (int cyc = 1; cyc <= 24 * NG + 12; cyc++) begin
         @(negedge Clock);
         if (cyc == 1) Enable = 1'b0;
         if (cyc == pulse_at) Enable = 1'b1;
         if (cyc == pulse_at + 1) Enable = 1'b0;
         if (Done) begin
            dones++;
            if (frame_cyc < 0) frame_cyc = cyc + 1;
         end
      end
   endtask

   logic [15:0] exp_u0, exp_v0;
   int          fc, dn;
   int unsigned w0;

   initial begin
`ifdef UV_AVG_EN
      exp_u0 = 16'h6D80;
      exp_v0 = 16'hB880;
`else
      exp_u0 = 16'h5A80;
      exp_v0 = 16'hF080;
`endif
      Resetn = 1'b0;
      Enable = 1'b0;
      for (int i = 0; i < 6 * NG; i++) src[int'(RB) + i] = 16'h0000;
      set_grp(0, '{16'hFF00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
      set_grp(1, '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF});
      set_grp(2, '{16'h0000, 16'hFF00, 16'h00FF, 16'h0000, 16'hFF00, 16'h00FF});

      repeat (3) @(negedge Clock);
      chk("rst_addr", 32'(SRAM_address), 32'd0);
      chk("rst_wdata", 32'(SRAM_write_data), 32'd0);
      chk("rst_we_n", 32'(SRAM_we_n), 32'd1);
      chk("rst_done", 32'(Done), 32'd0);
      Resetn = 1'b1;

      // Frame 1: red/white/blue groups then black, with a stray Enable pulse in group 1 S_CALC
      w0 = wr_cnt;
      run_frame(38, fc, dn);
      chk("f1_frame_cycles", 32'(fc), 32'(24 * NG + 2));
      chk("f1_done_count", 32'(dn), 32'd1);
      chk("f1_writes", 32'(wr_cnt - w0), 32'(4 * NG));
      chk_grp(0, 16'h5210, 16'h1010, exp_u0, exp_v0);
      chk_grp(1, 16'hEBEB, 16'hEBEB, 16'h8080, 16'h8080);
      chk_grp(2, 16'h2929, 16'h2929, 16'hF0F0, 16'h6E6E);
      for (int g = 3; g < NG; g++) chk_grp(g, 16'h1010, 16'h1010, 16'h8080, 16'h8080);

      // Enable held high: restart after Done, then abort with reset in group 5 S_WR
      @(negedge Clock);
      Enable = 1'b1;
      for (int i = 0; i < 24 * NG + 12; i++) begin
         if (Done) break;
         @(negedge Clock);
      end
      chk("held_done", 32'(Done), 32'd1);
      @(negedge Clock);
      @(negedge Clock);
      chk("restart_addr", 32'(SRAM_address), 32'(RB));
      chk("restart_we_n", 32'(SRAM_we_n), 32'd1);
      Enable = 1'b0;
      repeat (141) @(negedge Clock);
      chk("g5_wr_we_n", 32'(SRAM_we_n), 32'd0);
      Resetn = 1'b0;
      #1;
      chk("abort_addr", 32'(SRAM_address), 32'd0);
      chk("abort_wdata", 32'(SRAM_write_data), 32'd0);
      chk("abort_we_n", 32'(SRAM_we_n), 32'd1);
      chk("abort_done", 32'(Done), 32'd0);
      @(negedge Clock);
      Resetn = 1'b1;
      w0 = wr_cnt;
      repeat (30) @(negedge Clock);
      chk("no_resume_writes", 32'(wr_cnt - w0), 32'd0);
      chk("no_resume_addr", 32'(SRAM_address), 32'd0);

      // Frame 2: group 3 turned white so its outputs must be freshly written
      set_grp(3, '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF});
      w0 = wr_cnt;
      run_frame(0, fc, dn);
      chk("f2_frame_cycles", 32'(fc), 32'(24 * NG + 2));
      chk("f2_done_count", 32'(dn), 32'd1);
      chk("f2_writes", 32'(wr_cnt - w0), 32'(4 * NG));
      chk_grp(0, 16'h5210, 16'h1010, exp_u0, exp_v0);
      chk_grp(1, 16'hEBEB, 16'hEBEB, 16'h8080, 16'h8080);
      chk_grp(2, 16'h2929, 16'h2929, 16'hF0F0, 16'h6E6E);
      chk_grp(3, 16'hEBEB, 16'hEBEB, 16'h8080, 16'h8080);
      for (int g = 4; g < NG; g++) chk_grp(g, 16'h1010, 16'h1010, 16'h8080, 16'h8080);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
